// File: rtl/spi_master_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : spi_master_pkg                                     |
// | Description : Shared types and constants for the SPI master:     |
// |               FSM state encoding, register indices, status bit   |
// |               positions and a status-byte helper.                |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package spi_master_pkg;

    // FSM state encoding (explicit 2-bit width)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOW  = 2'd1;
    localparam state_t ST_HIGH = 2'd2;

    // Register window indices
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;
    localparam logic [1:0] REG_IRQ  = 2'd3;

    // Status byte bit positions
    localparam int STAT_BUSY   = 7;
    localparam int STAT_DONE   = 6;
    localparam int STAT_IRQ_EN = 5;
    localparam int STAT_CS0    = 0;

    // Assemble the CTRL/STATUS read value
    function automatic logic [7:0] status_byte(input logic busy, input logic done,
                                               input logic irq_en, input logic cs0);
        logic [7:0] s;
        s              = 8'h00;
        s[STAT_BUSY]   = busy;
        s[STAT_DONE]   = done;
        s[STAT_IRQ_EN] = irq_en;
        s[STAT_CS0]    = cs0;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : spi_sclk_gen                                       |
// | Description : Half-period divider for the SPI clock. While run   |
// |               is low the counter is held at div; while run is    |
// |               high it counts down and emits a one-cycle tick at  |
// |               zero, reloading from the current div value.        |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module spi_sclk_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] div,
    input  logic       run,
    output logic       tick
);

    logic [7:0] r_cnt;

    // Down-counter: restart while idle, reload at every half-period end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (!run || (r_cnt == 8'd0)) begin
            r_cnt <= div;
        end else begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign tick = run && (r_cnt == 8'd0);

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : spi_master                                         |
// | Description : Byte-wide mode-0 SPI master on the CPU bus.        |
// |               DATA write starts a transfer, DATA read returns    |
// |               the last received byte. Optional interrupt logic   |
// |               is enabled by defining SPI_MASTER_IRQ_EN.          |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module spi_master
    import spi_master_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic [1:0] addr,
    input  logic       we,
    input  logic       re,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
`ifdef SPI_MASTER_IRQ_EN
    output logic       irq,
`endif
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs0
);

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_div;
    logic       r_cs0;
    logic       r_done;
    logic [7:0] r_rx_data;
    logic [7:0] r_rx_shift;
    // Only the seven bits still to be sent after the current mosi bit
    logic [6:0] r_tx_shift;
    logic [2:0] r_bit_cnt;
    logic       r_sclk;
    logic       r_mosi;
    logic       w_irq_en;

    logic       w_tick;
    logic       w_run;
    logic       w_busy;
    logic       w_start;
    logic       w_rise;
    logic       w_fall;
    logic       w_last;

    logic       w_data_wr;
    logic       w_data_rd;
    logic       w_ctrl_wr;
    logic       w_div_wr;

    assign w_data_wr = cs && we && (addr == REG_DATA);
    assign w_data_rd = cs && re && (addr == REG_DATA);
    assign w_ctrl_wr = cs && we && (addr == REG_CTRL);
    assign w_div_wr  = cs && we && (addr == REG_DIV);

    spi_sclk_gen u_sclk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (r_div),
        .run   (w_run),
        .tick  (w_tick)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_data_wr) w_state_nxt = ST_LOW;
            ST_LOW:  if (w_tick)    w_state_nxt = ST_HIGH;
            ST_HIGH: if (w_tick)    w_state_nxt = (r_bit_cnt == 3'd7) ? ST_IDLE : ST_LOW;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode: datapath strobes for start, SCLK rise, SCLK fall
    always_comb begin
        w_start = 1'b0;
        w_rise  = 1'b0;
        w_fall  = 1'b0;
        w_last  = 1'b0;
        w_run   = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            ST_IDLE: w_start = w_data_wr;
            ST_LOW: begin
                w_run  = 1'b1;
                w_busy = 1'b1;
                w_rise = w_tick;
            end
            ST_HIGH: begin
                w_run  = 1'b1;
                w_busy = 1'b1;
                w_fall = w_tick;
                w_last = w_tick && (r_bit_cnt == 3'd7);
            end
            default: ;
        endcase
    end

    // Shift datapath: load on start, sample miso on rise, advance mosi on fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= 7'd0;
            r_rx_shift <= 8'd0;
            r_rx_data  <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b1;
        end else begin
            if (w_start) begin
                r_tx_shift <= wdata[6:0];
                r_mosi     <= wdata[7];
                r_bit_cnt  <= 3'd0;
            end
            if (w_rise) begin
                r_sclk     <= 1'b1;
                r_rx_shift <= {r_rx_shift[6:0], spi_miso};
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                if (w_last) begin
                    r_rx_data <= r_rx_shift;
                    r_mosi    <= 1'b1;
                end else begin
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    r_mosi     <= r_tx_shift[6];
                    r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                end
            end
        end
    end

    // Completion flag: set on last fall (wins over a same-cycle read), cleared on start or DATA read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else if (w_last) begin
            r_done <= 1'b1;
        end else if (w_start || w_data_rd) begin
            r_done <= 1'b0;
        end
    end

    // Software-visible control registers: chip select and divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs0 <= 1'b1;
            r_div <= DIV_RESET;
        end else begin
            if (w_ctrl_wr) r_cs0 <= wdata[0];
            if (w_div_wr)  r_div <= wdata;
        end
    end

`ifdef SPI_MASTER_IRQ_EN
    logic r_irq_en;
    logic w_irq_wr;

    assign w_irq_wr = cs && we && (addr == REG_IRQ);

    // Interrupt enable register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
        end else if (w_irq_wr) begin
            r_irq_en <= wdata[0];
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_done & r_irq_en;
`else
    assign w_irq_en = 1'b0;
`endif

    // Read-back mux on register index
    always_comb begin
        rdata = 8'h00;
        case (addr)
            REG_DATA: rdata = r_rx_data;
            REG_CTRL: rdata = status_byte(w_busy, r_done, w_irq_en, r_cs0);
            REG_DIV:  rdata = r_div;
            default:  rdata = {7'd0, w_irq_en};
        endcase
    end

    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_cs0  = r_cs0;

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

Byte-wide SPI master peripheral on the 6502 system bus. It drives the SD-card/flash port (spi0_sclk, spi0_mosi, spi0_cs0) and samples spi0_miso. The CPU writes a byte to start a mode-0 transfer and polls or takes an interrupt for completion. It sits between the CPU address decoder and the top-level SPI pins.

## Interface
- DIV_RESET, 8'd3: reset value of the clock divider register.
- clk  in  1  system clock (clk25 domain).
- rst_n  in  1  asynchronous, active-low reset.
- cs  in  1  register-window select from the address decoder.
- addr  in  2  register index.
- we  in  1  write strobe, qualified by cs, one clk cycle.
- re  in  1  read strobe, qualified by cs, one clk cycle.
- wdata  in  8  CPU write data.
- rdata  out  8  read data (combinational mux on addr).
- irq  out  1  level interrupt, only present with SPI_MASTER_IRQ_EN.
- spi_sclk  out  1  SPI clock, idle low.
- spi_mosi  out  1  serial data out, MSB first.
- spi_miso  in  1  serial data in; may float (z) while cs0 is high.
- spi_cs0  out  1  chip select, active low, software controlled.

## Operation
- Register map:
  - 0 DATA: a write starts a transfer; a read returns the last received byte.
  - 1 CTRL/STATUS: write bit0 = cs0 level. Read returns {busy, done, irq_en, 4'b0, cs0}.
  - 2 DIV: clocks per SCLK half-period = DIV+1.
  - 3 IRQCTL: bit0 = irq_en. Only present with the macro.
- FSM states: IDLE, LOW, HIGH.
- IDLE, DATA write: load tx_shift = wdata, drive mosi = wdata[7], set busy, clear done, bit_cnt = 0, div_cnt = DIV, go to LOW.
- LOW: sclk = 0. When div_cnt reaches 0, go to HIGH, set sclk = 1, sample miso into rx_shift[0] after shifting rx_shift left, reload div_cnt.
- HIGH: sclk = 1. When div_cnt reaches 0:
  - If bit_cnt = 7: rx_data = rx_shift, busy = 0, done = 1, sclk = 0, mosi = 1, go to IDLE.
  - Otherwise: bit_cnt++, shift tx_shift, mosi = next bit, sclk = 0, go to LOW.
- DATA write while busy: ignored. The transfer in flight is unaffected.
- A DIV write takes effect at the next reload. Writing DIV mid-transfer is legal.
- A cs0 write is applied immediately, even while busy. Software sequencing is responsible for correct framing.
- done clears on a DATA read (re with addr = 0) or on a new transfer start. If a DATA read and completion occur in the same cycle, completion wins and done = 1.
- Reset values:
  - Outputs: spi_sclk 0, spi_mosi 1, spi_cs0 1, irq 0.
  - Registers: rx_data 8'h00, busy 0, done 0, DIV = DIV_RESET, irq_en 0.
  - FSM: IDLE.
- Reset asserted mid-transfer aborts the transfer immediately. No partial data is kept.

## Timing
- Transfer length: 16*(DIV+1) clk cycles from the cycle after the DATA write to busy falling.
- DIV=0: SCLK period 2 clk. DIV=255: period 512 clk.
- mosi is valid one half-period before each rising SCLK edge.
- miso is sampled on the clk edge at which SCLK rises, with no synchronizer. Internally generated SCLK keeps this synchronous.
- STATUS reflects busy = 1 on the cycle after the start write.
- rx_data and done update on the same edge at which busy falls.
- irq follows done & irq_en combinationally from registered state, with no extra latency.

## Configuration
- SPI_MASTER_IRQ_EN defined:
  - irq port, IRQCTL register and the irq_en status bit exist.
  - irq = done & irq_en.
- Not defined:
  - No irq port.
  - Address 3 reads 8'h00 and writes to it are ignored.
  - Status bit5 reads 0.

## Structure
- Package spi_master_pkg holds:
  - the FSM state enum (IDLE, LOW, HIGH);
  - register index constants (REG_DATA=0, REG_CTRL=1, REG_DIV=2, REG_IRQ=3);
  - status bit positions.
- Sub-module spi_sclk_gen contains the half-period divider counter. It takes DIV and a run/restart input and outputs a one-cycle tick at each half-period end. The FSM and shift registers stay in spi_master.

## Test plan
- Reset: release rst_n, then check spi_sclk=0, spi_mosi=1, spi_cs0=1, STATUS=8'h01, DIV=8'h03.
- Loopback at DIV=0: write CTRL=0, DIV=0, DATA=8'hA5 with miso tied to mosi.
  - busy lasts 16 cycles.
  - mosi at rising edges reads 1,0,1,0,0,1,0,1.
  - DATA reads 8'hA5, done=1, then done=0 after the read.
- Divider at DIV=3: write DATA=8'h3C with miso=0.
  - 8 SCLK pulses, each high 4 clk and low 4 clk.
  - busy lasts 64 cycles; DATA reads 8'h00.
- Write while busy: write DATA=8'hFF 5 cycles after DATA=8'h12 with loopback. Only 8 SCLK pulses occur and DATA reads 8'h12.
- Reset mid-transfer: assert rst_n low after the 3rd SCLK pulse. Outputs return to reset values at once, STATUS=8'h01, and no further pulses occur.
- IRQ (macro on): write IRQCTL=1, then complete a transfer. irq rises with done, clears on the DATA read, and stays 0 when irq_en=0.
